// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one W-bit adder among NREQ requesters.
// Each operation is grant/capture, add, then hold the result until it is accepted.
module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_carry,
    output logic [IDW-1:0]    res_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]      state_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IDW-1:0]  last_id_reg;
    logic            res_valid_reg;
    logic [W-1:0]    res_sum_reg;
    logic            res_carry_reg;
    logic [IDW-1:0]  res_id_reg;

    logic [W-1:0]    a_arr   [NREQ];
    logic [W-1:0]    b_arr   [NREQ];
    logic [IDW-1:0]  cand_id [NREQ];
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [W:0]      sum_full;

    // cand_id[k] is the requester searched at position k after the last winner.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi]   = op_a[gi*W +: W];
            assign b_arr[gi]   = op_b[gi*W +: W];
            assign cand_id[gi] = IDW'((int'(last_id_reg) + gi + 1) % NREQ);
        end
    endgenerate

    // Scan from the lowest priority upward so the earliest match overrides.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand_id[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_id[k];
            end
        end
    end

    assign sum_full = {1'b0, a_reg} + {1'b0, b_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            last_id_reg   <= IDW'(NREQ - 1);
            res_valid_reg <= 1'b0;
            res_sum_reg   <= '0;
            res_carry_reg <= 1'b0;
            res_id_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        a_reg       <= a_arr[win_idx];
                        b_reg       <= b_arr[win_idx];
                        gnt_reg     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        last_id_reg <= win_idx;
                        state_reg   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    res_sum_reg   <= sum_full[W-1:0];
                    res_carry_reg <= sum_full[W];
                    res_id_reg    <= last_id_reg;
                    res_valid_reg <= 1'b1;
                    gnt_reg       <= '0;
                    state_reg     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign res_valid = res_valid_reg;
    assign res_sum   = res_sum_reg;
    assign res_carry = res_carry_reg;
    assign res_id    = res_id_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: fixed vector table, directed corner sequences and
// random traffic checked against a transaction-level model.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_carry;
    logic [IDW-1:0]    res_id;

    adder_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one operation in flight, grant -> result -> accept.
    int   last_win = NREQ - 1;
    logic [NREQ-1:0] m_gnt = '0;
    logic m_valid = 1'b0;
    logic m_zero  = 1'b1;
    int   m_sum = 0, m_carry = 0, m_id = 0;
    int   p_sum = 0, p_carry = 0, p_id = 0;

    task automatic model_edge();
        int  w, s, av, bv;
        bit  found;
        if (reset) begin
            m_gnt = '0; m_valid = 1'b0; m_zero = 1'b1;
            m_sum = 0; m_carry = 0; m_id = 0;
            last_win = NREQ - 1;
        end else if (m_gnt != 0) begin
            m_gnt = '0; m_valid = 1'b1; m_zero = 1'b0;
            m_sum = p_sum; m_carry = p_carry; m_id = p_id;
        end else if (m_valid) begin
            if (res_ready) m_valid = 1'b0;
        end else if (req != 0) begin
            found = 0;
            w = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && req[(last_win + k) % NREQ]) begin
                    found = 1;
                    w = (last_win + k) % NREQ;
                end
            end
            av = int'((op_a >> (w * W)) & 16'hF);
            bv = int'((op_b >> (w * W)) & 16'hF);
            s  = av + bv;
            p_sum = s % 16; p_carry = s / 16; p_id = w;
            m_gnt = NREQ'(1 << w);
            last_win = w;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("busy", 32'(busy), 32'((m_gnt != 0) || m_valid));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid || m_zero) begin
            check("res_sum", 32'(res_sum), 32'(m_sum));
            check("res_carry", 32'(res_carry), 32'(m_carry));
            check("res_id", 32'(res_id), 32'(m_id));
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic        rdy;
        logic        chk_res;
        logic [3:0]  gnt;
        logic        busy;
        logic        valid;
        logic [3:0]  sum;
        logic        carry;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs[11];
    int   gcount, prev_cyc;
    logic [3:0] order[5];

    initial begin
        // Expected values hold after the edge that consumes each row's inputs.
        vecs[0]  = '{1'b1, 4'hF, 16'h9C3A, 16'h51E7, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 4'h6, 16'h1234, 16'hFEDC, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 4'h2, 16'h0070, 16'h0050, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 4'hC, 1'b0, 2'd1};
        vecs[4]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 4'h8, 16'hF000, 16'h3000, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 4'h0, 16'hA5A5, 16'hA5A5, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd3};
        vecs[7]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[8]  = '{1'b0, 4'h8, 16'hF000, 16'hF000, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 4'hE, 1'b1, 2'd3};
        vecs[10] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        order[0] = 4'h1; order[1] = 4'h2; order[2] = 4'h4; order[3] = 4'h8; order[4] = 4'h1;

        reset = 1'b1; req = '0; op_a = '0; op_b = '0; res_ready = 1'b0;

        // Reset, single request, overflow cases.
        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst; req = vecs[i].req; op_a = vecs[i].a;
            op_b = vecs[i].b; res_ready = vecs[i].rdy;
            tick();
            check("tbl_gnt", 32'(gnt), 32'(vecs[i].gnt));
            check("tbl_busy", 32'(busy), 32'(vecs[i].busy));
            check("tbl_valid", 32'(res_valid), 32'(vecs[i].valid));
            if (vecs[i].chk_res) begin
                check("tbl_sum", 32'(res_sum), 32'(vecs[i].sum));
                check("tbl_carry", 32'(res_carry), 32'(vecs[i].carry));
                check("tbl_id", 32'(res_id), 32'(vecs[i].id));
            end
            $display("vec %0d: req=%h gnt=%h busy=%b valid=%b sum=%h carry=%b id=%0d",
                     i, vecs[i].req, gnt, busy, res_valid, res_sum, res_carry, res_id);
        end

        // All requesters held: strict rotation, one grant every 3 cycles.
        req = 4'hF; res_ready = 1'b1;
        gcount = 0; prev_cyc = 0;
        for (int c = 0; c < 15; c++) begin
            op_a = 16'($urandom); op_b = 16'($urandom);
            tick();
            if (gnt != 0) begin
                if (gcount < 5) check("rr_order", 32'(gnt), 32'(order[gcount]));
                if (gcount > 0) check("rr_spacing", 32'(c - prev_cyc), 32'd3);
                $display("rr grant %0d: gnt=%h cycle=%0d", gcount, gnt, c);
                prev_cyc = c;
                gcount++;
            end
        end
        check("rr_count", 32'(gcount), 32'd5);

        req = '0;
        repeat (3) tick();

        // Backpressure: result held while operands churn and others request.
        req = 4'h4; op_a = 16'h0900; op_b = 16'h0800; res_ready = 1'b0;
        tick();
        check("bp_grant", 32'(gnt), 32'h4);
        req = 4'hF;
        tick();
        for (int c = 0; c < 5; c++) begin
            op_a = 16'($urandom); op_b = 16'($urandom);
            tick();
            check("bp_sum", 32'(res_sum), 32'h1);
            check("bp_carry", 32'(res_carry), 32'h1);
            check("bp_id", 32'(res_id), 32'd2);
            check("bp_nognt", 32'(gnt), 32'h0);
            check("bp_valid", 32'(res_valid), 32'h1);
        end
        res_ready = 1'b1;
        tick();
        check("bp_release", 32'(res_valid), 32'h0);
        tick();
        check("bp_next_grant", 32'(gnt), 32'h8);

        // Reset while a result is held, then requester 0 wins first.
        res_ready = 1'b0; req = '0;
        repeat (2) tick();
        check("hold_valid", 32'(res_valid), 32'h1);
        reset = 1'b1;
        tick();
        check("rst_all", 32'({gnt, busy, res_valid, res_sum, res_carry, res_id}), 32'h0);
        reset = 1'b0; req = 4'h9; res_ready = 1'b1;
        tick();
        check("rst_first_grant", 32'(gnt), 32'h1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(99) == 0);
            req       = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            res_ready = ($urandom_range(3) != 0);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
